// File: rtl/stream_serializer_if.sv
// Valid/ready bundle for the wide-in, narrow-out serializer.
// The slave modport is the serializer; the master modport is its environment.
interface stream_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int IDX_WIDTH  = $clog2(RATIO)
);
    logic                          w_valid;
    logic                          w_ready;
    logic [RATIO*DATA_WIDTH-1:0]   w_data;
    logic [IDX_WIDTH-1:0]          w_count;
    logic                          w_last;
    logic                          r_valid;
    logic                          r_ready;
    logic [DATA_WIDTH-1:0]         r_data;
    logic                          r_last;

    modport slave (
        input  w_valid, w_data, w_count, w_last, r_ready,
        output w_ready, r_valid, r_data, r_last
    );

    modport master (
        output w_valid, w_data, w_count, w_last, r_ready,
        input  w_ready, r_valid, r_data, r_last
    );
endinterface

// File: rtl/stream_serializer.sv
// Width-down converter: one wide beat of RATIO lanes out as narrow beats.
// Registered narrow side; only r_ready reaches w_ready combinationally.
module stream_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int IDX_WIDTH  = $clog2(RATIO)
) (
    input  logic               clk,
    input  logic               rstn,
    stream_serializer_if.slave bus
);
    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t                           state_q, state_d;
    logic [IDX_WIDTH-1:0]             idx_q, idx_d;
    logic [IDX_WIDTH-1:0]             cnt_q, cnt_in;
    logic [RATIO-1:0][DATA_WIDTH-1:0] hold_q;
    logic                             last_q;
    logic                             busy;
    logic                             final_lane;
    logic                             accept;

    // Counts beyond the last lane only exist when RATIO is not a power of two
    generate
        if ((1 << IDX_WIDTH) != RATIO) begin : g_clamp
            localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(RATIO - 1);
            assign cnt_in = (bus.w_count > MAX_IDX) ? MAX_IDX : bus.w_count;
        end else begin : g_pass
            assign cnt_in = bus.w_count;
        end
    endgenerate

    assign busy       = (state_q == S_BUSY);
    assign final_lane = busy && (idx_q == cnt_q);
    assign accept     = bus.w_valid && bus.w_ready;

    assign bus.w_ready = !busy || (final_lane && bus.r_ready);
    assign bus.r_valid = busy;
    assign bus.r_data  = hold_q[idx_q];
    assign bus.r_last  = last_q && (idx_q == cnt_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_q <= bus.w_data;
            cnt_q  <= cnt_in;
            last_q <= bus.w_last;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    idx_d   = '0;
                end
            end
            S_BUSY: begin
                if (accept) begin
                    idx_d = '0;
                end else if (bus.r_ready) begin
                    if (final_lane) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: RATIO=4 main instance plus a
// RATIO=3 instance for the out-of-range count clamp.
module tb_stream_serializer;
    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   hs;

    stream_serializer_if #(.DATA_WIDTH(8), .RATIO(4)) b4 ();
    stream_serializer_if #(.DATA_WIDTH(8), .RATIO(3)) b3 ();

    stream_serializer #(.DATA_WIDTH(8), .RATIO(4)) u4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b4.slave)
    );

    stream_serializer #(.DATA_WIDTH(8), .RATIO(3)) u3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic send4(input logic [31:0] d, input logic [1:0] c,
                         input logic l);
        b4.w_valid = 1'b1;
        b4.w_data  = d;
        b4.w_count = c;
        b4.w_last  = l;
    endtask

    logic [7:0] exp_lane[7];
    logic       pat_rdy[7];

    initial begin
        total      = 0;
        bad        = 0;
        hs         = 0;
        rstn       = 1'b0;
        b4.w_valid = 1'b0;
        b4.w_data  = '0;
        b4.w_count = '0;
        b4.w_last  = 1'b0;
        b4.r_ready = 1'b1;
        b3.w_valid = 1'b0;
        b3.w_data  = '0;
        b3.w_count = '0;
        b3.w_last  = 1'b0;
        b3.r_ready = 1'b1;

        // reset state
        tick();
        settle();
        chk("rst_rvalid", 32'(b4.r_valid), 32'd0);
        chk("rst_wready", 32'(b4.w_ready), 32'd1);
        chk("rst_rvalid3", 32'(b3.r_valid), 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // scenario 1: four lanes, full rate
        send4(32'h44332211, 2'd3, 1'b1);
        settle();
        chk("s1_acc_wready", 32'(b4.w_ready), 32'd1);
        tick();
        b4.w_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("s1_rvalid", 32'(b4.r_valid), 32'd1);
            chk("s1_rdata", 32'(b4.r_data), 32'(8'h11 * (i + 1)));
            chk("s1_rlast", 32'(b4.r_last), 32'(i == 3));
            chk("s1_wready", 32'(b4.w_ready), 32'(i == 3));
            tick();
        end
        settle();
        chk("s1_idle_rvalid", 32'(b4.r_valid), 32'd0);
        chk("s1_idle_wready", 32'(b4.w_ready), 32'd1);
        tick();

        // scenario 2: back-to-back beats, no bubble
        send4(32'hAABBCCDD, 2'd3, 1'b0);
        tick();
        send4(32'h00000099, 2'd0, 1'b1);
        exp_lane[0] = 8'hDD;
        exp_lane[1] = 8'hCC;
        exp_lane[2] = 8'hBB;
        exp_lane[3] = 8'hAA;
        exp_lane[4] = 8'h99;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("s2_rvalid", 32'(b4.r_valid), 32'd1);
            chk("s2_rdata", 32'(b4.r_data), 32'(exp_lane[i]));
            chk("s2_rlast", 32'(b4.r_last), 32'(i == 4));
            chk("s2_wready", 32'(b4.w_ready), 32'(i >= 3));
            tick();
            if (i == 3) b4.w_valid = 1'b0;
        end
        settle();
        chk("s2_idle_rvalid", 32'(b4.r_valid), 32'd0);
        tick();

        // scenario 3: backpressure
        send4(32'h44332211, 2'd3, 1'b1);
        tick();
        b4.w_valid = 1'b0;
        pat_rdy    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_lane   = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
        hs         = 0;
        for (int i = 0; i < 7; i++) begin
            b4.r_ready = pat_rdy[i];
            settle();
            chk("s3_rvalid", 32'(b4.r_valid), 32'd1);
            chk("s3_rdata", 32'(b4.r_data), 32'(exp_lane[i]));
            chk("s3_rlast", 32'(b4.r_last), 32'(i >= 5));
            if (b4.r_valid && b4.r_ready) hs++;
            tick();
        end
        b4.r_ready = 1'b1;
        settle();
        chk("s3_handshakes", 32'(hs), 32'd4);
        chk("s3_idle_rvalid", 32'(b4.r_valid), 32'd0);
        tick();

        // scenario 4: two lanes, no packet end
        send4(32'h0000BEEF, 2'd1, 1'b0);
        tick();
        b4.w_valid = 1'b0;
        settle();
        chk("s4_lane0", 32'(b4.r_data), 32'hEF);
        chk("s4_last0", 32'(b4.r_last), 32'd0);
        tick();
        settle();
        chk("s4_lane1", 32'(b4.r_data), 32'hBE);
        chk("s4_last1", 32'(b4.r_last), 32'd0);
        chk("s4_rvalid1", 32'(b4.r_valid), 32'd1);
        tick();
        settle();
        chk("s4_idle_rvalid", 32'(b4.r_valid), 32'd0);
        chk("s4_idle_wready", 32'(b4.w_ready), 32'd1);
        tick();

        // scenario 5: reset mid-packet
        send4(32'h44332211, 2'd3, 1'b1);
        tick();
        b4.w_valid = 1'b0;
        settle();
        chk("s5_lane0", 32'(b4.r_data), 32'h11);
        tick();
        settle();
        chk("s5_lane1", 32'(b4.r_data), 32'h22);
        tick();
        rstn = 1'b0;
        #1;
        chk("s5_rst_rvalid", 32'(b4.r_valid), 32'd0);
        tick();
        rstn = 1'b1;
        settle();
        chk("s5_post_wready", 32'(b4.w_ready), 32'd1);
        chk("s5_post_rvalid", 32'(b4.r_valid), 32'd0);
        tick();
        settle();
        chk("s5_stale_rvalid", 32'(b4.r_valid), 32'd0);
        tick();
        send4(32'h0A0B0C0D, 2'd3, 1'b1);
        tick();
        b4.w_valid = 1'b0;
        exp_lane[0] = 8'h0D;
        exp_lane[1] = 8'h0C;
        exp_lane[2] = 8'h0B;
        exp_lane[3] = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("s5_rdata", 32'(b4.r_data), 32'(exp_lane[i]));
            chk("s5_rlast", 32'(b4.r_last), 32'(i == 3));
            tick();
        end
        settle();
        chk("s5_idle_rvalid", 32'(b4.r_valid), 32'd0);
        tick();

        // scenario 6: RATIO=3 clamps an out-of-range count
        b3.w_valid = 1'b1;
        b3.w_data  = 24'h030201;
        b3.w_count = 2'd3;
        b3.w_last  = 1'b1;
        tick();
        b3.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("s6_rvalid", 32'(b3.r_valid), 32'd1);
            chk("s6_rdata", 32'(b3.r_data), 32'(i + 1));
            chk("s6_rlast", 32'(b3.r_last), 32'(i == 2));
            tick();
        end
        settle();
        chk("s6_idle_rvalid", 32'(b3.r_valid), 32'd0);
        chk("s6_idle_wready", 32'(b3.w_ready), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
